i2s_tx_serializer: RTL and testbench
====================================

Name: i2s_tx_serializer

Overview:
- Downstream stage of the Karplus-Strong core.
- Takes left/right audio sample pairs over a valid/ready handshake and holds one pair in a single-entry buffer.
- Serializes each pair as standard I2S, MSB first, with the one-bit WS delay; it is the controller generating i2s_sck and i2s_ws.
- Drives uio_out[4] (sck), uio_out[5] (ws) and uio_out[6] (sd); flags underrun for the status registers.

Parameters:
- AUDIO_DW, 8, sample width per channel.
- SCK_DIV, 1, clk cycles per i2s_sck half-period (>=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- ena  in  1  run enable; low freezes all state and outputs.
- l_data  in  AUDIO_DW  left sample.
- r_data  in  AUDIO_DW  right sample.
- s_valid  in  1  sample pair valid.
- s_ready  out  1  buffer can accept a pair.
- i2s_sck  out  1  serial bit clock.
- i2s_ws  out  1  word select (0 = left, 1 = right).
- i2s_sd  out  1  serial data.
- frame_start  out  1  one-clk pulse on entry to slot 0.
- underrun  out  1  sticky underrun flag.
- underrun_clr  in  1  synchronous clear of underrun.

Behaviour:
- Reset values: i2s_sck=0, i2s_ws=1, i2s_sd=0, s_ready=1, frame_start=0, underrun=0.
  - Internal reset: divider=0, slot=2*AUDIO_DW-1, buffer empty, shift regs=0, last_r_lsb=0.
- Divider:
  - Counts 0..SCK_DIV-1 while ena=1; at terminal count it wraps and i2s_sck toggles.
  - A 1->0 toggle is a "fall event".
- Slot counter:
  - 0..2*AUDIO_DW-1; advances on each fall event and wraps 2*AUDIO_DW-1 -> 0.
  - ws, sd and slot all update on the same clk edge as the fall event (i.e. on falling sck).
- WS: 0 for slots 0..AUDIO_DW-1, 1 for slots AUDIO_DW..2*AUDIO_DW-1.
- SD:
  - slot 0 = last_r_lsb (previous frame's right LSB).
  - slots 1..AUDIO_DW = left bit AUDIO_DW-1 down to 0.
  - slots AUDIO_DW+1..2*AUDIO_DW-1 = right bit AUDIO_DW-1 down to 1.
  - Right bit 0 goes out in slot 0 of the next frame.
- Frame load, on entry to slot 0:
  - last_r_lsb <= current right shift reg bit 0; frame_start pulses this clk.
  - If the buffer is full: shift regs <= buffer, buffer empty.
  - Otherwise: underrun <= 1, and shift regs keep the previous pair (repeat).
- Handshake:
  - s_ready = !buffer_full, registered.
  - Accept on clk with s_valid && s_ready → buffer <= {l_data, r_data}, s_ready drops next clk.
  - Accept and frame load in the same clk: the load takes the old buffer content (buffer must already be full for a load). Because s_ready=0 when full, this cannot collide.
  - s_ready returns to 1 the clk after the frame load.
  - s_valid with s_ready=0 is ignored; the source holds its data.
- underrun_clr clears the flag; a simultaneous set (underrun event) wins.
- ena=0: divider, slot, sck, ws and sd hold; the handshake still accepts into an empty buffer.
- rst mid-frame: immediate return to reset values; any partially sent word is discarded.
- Latency: a pair accepted before slot 0 has its left MSB on sd 1 sck later, i.e. 2*SCK_DIV clk after frame_start.

Optional Feature:
- Macro: I2S_ZERO_ON_UNDERRUN_EN.
- Defined: on underrun, shift regs load all zeros (silence); the underrun flag behaves as usual.
- Undefined: on underrun, the previous pair repeats. After reset with no pair ever pushed, the output is zeros in both cases.

Test Plan:
- Reset: assert rst with ena=1 → i2s_sck=0, i2s_ws=1, i2s_sd=0, s_ready=1, underrun=0; release → first frame_start 2*SCK_DIV clk later.
- Single pair, AUDIO_DW=8, SCK_DIV=1: push L=0xA5, R=0x3C before first frame_start → bench receiver (sample sd on sck rise, latch on WS edge) gets L=0xA5, R=0x3C; ws period 32 clk; underrun stays 0.
- Back-to-back: push 0x11/0x22, then hold 0x33/0x44 valid → s_ready=0 until the frame_start after the first load; frames carry 0x11/0x22 then 0x33/0x44 with nothing lost or duplicated.
- Underrun: push 0xA5/0x3C once, then none → next frame repeats 0xA5/0x3C (0x00/0x00 with the macro) and underrun=1; pulse underrun_clr → 0, then set again at the following frame_start.
- Clear vs set: pulse underrun_clr on the same clk as an underrun frame_start → underrun stays 1.
- SCK_DIV=4, ena toggled low for 10 clk mid-frame → sck period 8 clk, ws period 128 clk plus the 10-clk freeze; ws changes on falling sck one sck before each MSB; data intact.

Source files
------------

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer
//   Downstream stage of the Karplus-Strong core. Accepts left/right sample
//   pairs over valid/ready into a single-entry buffer and sends them as
//   standard I2S (MSB first, one-bit WS delay). This block is the bus
//   controller, so it generates i2s_sck and i2s_ws itself.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   ena             run enable; low freezes divider, slot, sck, ws and sd
//   l_data, r_data  sample pair, s_valid/s_ready handshake
//   i2s_sck/ws/sd   serial bit clock, word select (0 = left), serial data
//   frame_start     one-clk pulse on entry to slot 0
//   underrun        sticky flag, set when a frame starts with no pair ready
//   underrun_clr    synchronous clear of underrun (a simultaneous set wins)
//
// Build option:
//   I2S_ZERO_ON_UNDERRUN_EN  defined: an underrun frame sends silence.
//                            undefined: an underrun frame repeats the last pair.
module i2s_tx_serializer #(
    parameter int AUDIO_DW = 8,
    parameter int SCK_DIV  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic [AUDIO_DW-1:0] l_data,
    input  logic [AUDIO_DW-1:0] r_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                i2s_sck,
    output logic                i2s_ws,
    output logic                i2s_sd,
    output logic                frame_start,
    output logic                underrun,
    input  logic                underrun_clr
);

    localparam int SLOTS = 2 * AUDIO_DW;
    localparam int SW    = $clog2(SLOTS);
    localparam int CW    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(SCK_DIV - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);
    localparam logic [SW-1:0] SLOT_WS   = SW'(AUDIO_DW);

    logic [CW-1:0]       div_cnt;
    logic [SW-1:0]       slot;
    logic [SW-1:0]       slot_nxt;
    logic [SW-1:0]       bit_idx;
    logic [AUDIO_DW-1:0] buf_l, buf_r;
    logic [AUDIO_DW-1:0] sh_l, sh_r;
    logic [SLOTS-1:0]    frame_bits;
    logic                buf_full, buf_full_nxt;
    logic                last_r_lsb;
    logic                tick, fall, wrap, accept;

    always_comb begin
        tick     = ena && (div_cnt == DIV_LAST);
        fall     = tick && i2s_sck;
        slot_nxt = (slot == SLOT_LAST) ? '0 : slot + 1'b1;
        wrap     = fall && (slot == SLOT_LAST);
        accept   = s_valid && s_ready;

        // A load can only consume a full buffer and an accept only fills an
        // empty one, so the two never act on the same pair.
        buf_full_nxt = buf_full;
        if (wrap && buf_full)
            buf_full_nxt = 1'b0;
        if (accept)
            buf_full_nxt = 1'b1;
    end

    // SD is decoded from registered state that only changes on the falling
    // sck edge: slot k (1..SLOTS-1) carries bit SLOTS-k of {left, right},
    // slot 0 carries the previous frame's right LSB.
    always_comb begin
        frame_bits = {sh_l, sh_r};
        bit_idx    = SW'(SLOTS - int'(slot));
        i2s_sd     = (slot == '0) ? last_r_lsb : frame_bits[bit_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= '0;
            slot        <= SLOT_LAST;
            i2s_sck     <= 1'b0;
            i2s_ws      <= 1'b1;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            s_ready     <= 1'b1;
            buf_full    <= 1'b0;
            buf_l       <= '0;
            buf_r       <= '0;
            sh_l        <= '0;
            sh_r        <= '0;
            last_r_lsb  <= 1'b0;
        end else begin
            frame_start <= 1'b0;

            if (ena)
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick)
                i2s_sck <= ~i2s_sck;

            if (fall) begin
                slot   <= slot_nxt;
                i2s_ws <= (slot_nxt >= SLOT_WS);
            end

            if (wrap) begin
                last_r_lsb  <= sh_r[0];
                frame_start <= 1'b1;
                if (buf_full) begin
                    sh_l <= buf_l;
                    sh_r <= buf_r;
                end else begin
`ifdef I2S_ZERO_ON_UNDERRUN_EN
                    sh_l <= '0;
                    sh_r <= '0;
`endif
                end
            end

            if (accept) begin
                buf_l <= l_data;
                buf_r <= r_data;
            end
            buf_full <= buf_full_nxt;
            s_ready  <= !buf_full_nxt;

            if (wrap && !buf_full)
                underrun <= 1'b1;
            else if (underrun_clr)
                underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
module tb_i2s_tx_serializer;
    localparam int DW = 8;

`ifdef I2S_ZERO_ON_UNDERRUN_EN
    localparam logic [15:0] REPEAT_PAIR = 16'h0000;
`else
    localparam logic [15:0] REPEAT_PAIR = 16'hA53C;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          ena1, v1, rdy1, sck1, ws1, sd1, fs1, ur1, clr1;
    logic [DW-1:0] l1, r1;
    logic          ena4, v4, rdy4, sck4, ws4, sd4, fs4, ur4, clr4;
    logic [DW-1:0] l4, r4;

    i2s_tx_serializer #(.AUDIO_DW(DW), .SCK_DIV(1)) dut1 (
        .clk(clk), .rst(rst), .ena(ena1), .l_data(l1), .r_data(r1),
        .s_valid(v1), .s_ready(rdy1), .i2s_sck(sck1), .i2s_ws(ws1),
        .i2s_sd(sd1), .frame_start(fs1), .underrun(ur1), .underrun_clr(clr1)
    );

    i2s_tx_serializer #(.AUDIO_DW(DW), .SCK_DIV(4)) dut4 (
        .clk(clk), .rst(rst), .ena(ena4), .l_data(l4), .r_data(r4),
        .s_valid(v4), .s_ready(rdy4), .i2s_sck(sck4), .i2s_ws(ws4),
        .i2s_sd(sd4), .frame_start(fs4), .underrun(ur4), .underrun_clr(clr4)
    );

    // receiver taps follow whichever instance is under test
    logic use4;
    logic sck_m, ws_m, sd_m, fs_m;
    assign sck_m = use4 ? sck4 : sck1;
    assign ws_m  = use4 ? ws4  : ws1;
    assign sd_m  = use4 ? sd4  : sd1;
    assign fs_m  = use4 ? fs4  : fs1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait for the next 0->1 of sck, sampled 1 time unit after each clk edge
    task automatic wait_rise(output bit ok);
        logic p;
        int   n;
        p  = sck_m;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(posedge clk); #1;
            n++;
            if (p === 1'b0 && sck_m === 1'b1) ok = 1'b1;
            p = sck_m;
        end
    endtask

    // count clk edges until frame_start is seen
    task automatic wait_fs(output int n);
        bit got;
        got = 1'b0;
        n   = 0;
        while (!got && n < 400) begin
            @(posedge clk); #1;
            n++;
            got = (fs_m === 1'b1);
        end
        chk("fs_wait", {31'd0, got}, 32'd1);
    endtask

    // I2S receiver: entered just after the slot-0 rise, samples sd/ws on the
    // next 16 sck rises (slots 1..15, then slot 0 of the next frame).
    // Result is {left, right}; span is clk count from first to last rise.
    task automatic capture(input int freeze_at, output logic [15:0] data,
                           output logic [15:0] ws_v, output int span);
        int c0;
        bit ok;
        data = '0;
        ws_v = '0;
        span = 0;
        c0   = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == freeze_at) begin
                ena4 = 1'b0;
                repeat (10) @(posedge clk);
                #1;
                ena4 = 1'b1;
            end
            wait_rise(ok);
            if (!ok) chk("rise_timeout", {31'd0, ok}, 32'd1);
            data = {data[14:0], sd_m};
            ws_v = {ws_v[14:0], ws_m};
            if (i == 0)  c0 = cyc;
            if (i == 15) span = cyc - c0;
        end
    endtask

    initial begin
        logic [15:0] d, w;
        int          span, n;
        bit          ok;

        rst  = 1'b1;
        use4 = 1'b0;
        ena1 = 1'b1; v1 = 1'b0; l1 = '0; r1 = '0; clr1 = 1'b0;
        ena4 = 1'b0; v4 = 1'b0; l4 = '0; r4 = '0; clr4 = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sck",   {31'd0, sck1}, 32'd0);
        chk("rst_ws",    {31'd0, ws1},  32'd1);
        chk("rst_sd",    {31'd0, sd1},  32'd0);
        chk("rst_ready", {31'd0, rdy1}, 32'd1);
        chk("rst_fs",    {31'd0, fs1},  32'd0);
        chk("rst_ur",    {31'd0, ur1},  32'd0);
        chk("rst_ready4", {31'd0, rdy4}, 32'd1);

        // single pair pushed before the first frame
        rst = 1'b0;
        v1 = 1'b1; l1 = 8'hA5; r1 = 8'h3C;
        @(posedge clk); #1;
        v1 = 1'b0;
        wait_fs(n);
        chk("fs_latency", n + 1, 32'd2);
        chk("ur_first", {31'd0, ur1}, 32'd0);
        wait_rise(ok);
        chk("rise_slot0", {31'd0, ok}, 32'd1);
        capture(-1, d, w, span);
        chk("pair_a53c", {16'd0, d}, 32'h0000A53C);
        chk("ws_pattern", {16'd0, w}, 32'h000001FE);
        chk("sck_span",  span, 32'd30);

        // no further pairs: underrun frame
        chk("ur_set", {31'd0, ur1}, 32'd1);
        capture(-1, d, w, span);
        chk("pair_repeat", {16'd0, d}, {16'd0, REPEAT_PAIR});

        // clear, then set again at the following frame_start
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        chk("ur_clr", {31'd0, ur1}, 32'd0);
        wait_fs(n);
        chk("fs_interval", n, 32'd30);
        chk("ur_reset", {31'd0, ur1}, 32'd1);

        // clear coinciding with an underrun frame_start: set wins
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        chk("ur_clr2", {31'd0, ur1}, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        clr1 = 1'b1;
        @(posedge clk); #1;
        clr1 = 1'b0;
        chk("fs_on_clr", {31'd0, fs1}, 32'd1);
        chk("ur_set_wins", {31'd0, ur1}, 32'd1);

        // back-to-back pairs
        v1 = 1'b1; l1 = 8'h11; r1 = 8'h22;
        @(posedge clk); #1;
        l1 = 8'h33; r1 = 8'h44;
        @(posedge clk); #1;
        chk("b2b_ready_low", {31'd0, rdy1}, 32'd0);
        wait_fs(n);
        chk("b2b_ready_back", {31'd0, rdy1}, 32'd1);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("b2b_ready_low2", {31'd0, rdy1}, 32'd0);
        capture(-1, d, w, span);
        chk("b2b_first", {16'd0, d}, 32'h00001122);
        capture(-1, d, w, span);
        chk("b2b_second", {16'd0, d}, 32'h00003344);

        // SCK_DIV=4 instance: accept while disabled, then freeze mid-frame
        use4 = 1'b1;
        v4 = 1'b1; l4 = 8'h96; r4 = 8'h5A;
        @(posedge clk); #1;
        v4 = 1'b0;
        chk("div4_accept_idle", {31'd0, rdy4}, 32'd0);
        ena4 = 1'b1;
        wait_fs(n);
        chk("div4_fs_latency", n, 32'd8);
        wait_rise(ok);
        chk("div4_rise_slot0", {31'd0, ok}, 32'd1);
        capture(5, d, w, span);
        chk("div4_pair", {16'd0, d}, 32'h0000965A);
        chk("div4_ws", {16'd0, w}, 32'h000001FE);
        chk("div4_span", span, 32'd130);
        chk("div4_ur", {31'd0, ur4}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
